seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a bank of common-anode seven-segment digits. It captures a packed hex word once per frame, decodes one nibble at a time to active-low segment patterns, and scans the digits one after another. Anode-off guard cycles between digits prevent ghosting. The block sits between the display datapath and the board pins, and replaces per-digit combinational decoding.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_hex_decoder.sv | 25 ++
 rtl/seven_segment_scanner.sv | 183 ++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
//   SEG_A..SEG_G : bit positions of each segment in a 7-bit pattern
//   SEG_OFF      : active-low pattern with every segment dark
//   SEG_PATTERN  : active-high hex glyphs, indexed by nibble value
//   scan_state_t : scan FSM states
package seg_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_PATTERN [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble : 4-bit hex digit
//   seg_n  : active-low segments, [6] = a ... [0] = g
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  logic [6:0] pat;

  always_comb begin
    pat          = SEG_PATTERN[nibble];
    seg_n        = SEG_OFF;
    seg_n[SEG_A] = ~pat[SEG_A];
    seg_n[SEG_B] = ~pat[SEG_B];
    seg_n[SEG_C] = ~pat[SEG_C];
    seg_n[SEG_D] = ~pat[SEG_D];
    seg_n[SEG_E] = ~pat[SEG_E];
    seg_n[SEG_F] = ~pat[SEG_F];
    seg_n[SEG_G] = ~pat[SEG_G];
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver.
// Alternates GUARD (all anodes off) and SHOW (one digit lit), stepping the
// digit index after each SHOW. Inputs are snapshotted once per frame when
// digit 0 is about to be shown, so a frame never mixes old and new data.
//   clk, rst    : clock, asynchronous active-high reset
//   value       : packed hex nibbles, digit 0 in [3:0]
//   dp          : per-digit decimal point enable (1 = lit)
//   blank       : per-digit force dark (1 = dark, also darks dp)
//   lz_en       : leading-zero suppression enable
//   seg_n       : active-low segments, [6] = a ... [0] = g
//   dp_n        : active-low decimal point
//   an_n        : active-low anodes
//   frame_tick  : pulse on the first SHOW cycle of digit 0
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_start;

  logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic                    snap_lz_q, snap_lz_d;

  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_above;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg_n;
  logic                  dp_sel, blank_sel, supp_sel;
  logic [NUM_DIGITS-1:0] an_sel;

  logic [6:0]            seg_d;
  logic                  dp_n_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  frame_tick_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; the index advances when leaving SHOW, so during
  // GUARD it already names the digit about to be shown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign frame_start = (state_q == GUARD) && (cnt_q == GUARD_LAST) && (idx_q == '0);

  // Output registers are loaded from next-state values so they stay
  // aligned with the state register; the snapshot seen by the decoder is
  // the one being loaded on this edge, so the first digit-0 cycle already
  // shows the new frame's data.
  assign snap_value_d = frame_start ? value : snap_value_q;
  assign snap_dp_d    = frame_start ? dp    : snap_dp_q;
  assign snap_blank_d = frame_start ? blank : snap_blank_q;
  assign snap_lz_d    = frame_start ? lz_en : snap_lz_q;

  // A digit is suppressed while it and everything above it are zero;
  // digit 0 is never included in the scan.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (snap_value_d[(NUM_DIGITS-1-k)*4 +: 4] != 4'h0) zero_above = 1'b0;
      supp[NUM_DIGITS-1-k] = snap_lz_d & zero_above;
    end
  end

  always_comb begin
    nibble    = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    supp_sel  = 1'b0;
    an_sel    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nibble    = snap_value_d[i*4 +: 4];
        dp_sel    = snap_dp_d[i];
        blank_sel = snap_blank_d[i];
        supp_sel  = supp[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg_n)
  );

  // Output logic
  always_comb begin
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_n_d       = 1'b1;
    frame_tick_d = frame_start;
    if (state_d == SHOW) begin
      an_d   = an_sel;
      seg_d  = (blank_sel || supp_sel) ? SEG_OFF : dec_seg_n;
      dp_n_d = ~(dp_sel & ~blank_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_lz_q    <= 1'b0;
      an_n         <= '1;
      seg_n        <= SEG_OFF;
      dp_n         <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      snap_lz_q    <= snap_lz_d;
      an_n         <= an_d;
      seg_n        <= seg_d;
      dp_n         <= dp_n_d;
      frame_tick   <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .GUARD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},   16'(an_n),       16'h000F);
    chk({tag, "_seg"},  16'(seg_n),      16'h007F);
    chk({tag, "_dp"},   16'(dp_n),       16'h0001);
    chk({tag, "_tick"}, 16'(frame_tick), 16'h0000);
  endtask

  // One 20-cycle frame starting with the first digit-0 SHOW cycle.
  // segs = {d3, d2, d1, d0} expected seg_n; dpn[i] = expected dp_n on digit i.
  // At cycle chg_at (after its checks) value is replaced with chg_val.
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dpn,
                             input int chg_at, input logic [15:0] chg_val);
    logic [3:0] sel;
    logic [3:0] exp_an;
    for (int p = 0; p < 20; p++) begin
      @(negedge clk);
      if (p % 5 == 4) begin
        chk("guard_an",  16'(an_n),  16'h000F);
        chk("guard_seg", 16'(seg_n), 16'h007F);
        chk("guard_dp",  16'(dp_n),  16'h0001);
      end else begin
        sel    = 4'b0001 << (p / 5);
        exp_an = ~sel;
        chk("show_an",  16'(an_n),  16'(exp_an));
        chk("show_seg", 16'(seg_n), 16'(segs[(p/5)*7 +: 7]));
        chk("show_dp",  16'(dp_n),  16'(dpn[p/5]));
      end
      chk("frame_tick", 16'(frame_tick), 16'(p == 0));
      if (p == chg_at) value = chg_val;
    end
  endtask

  initial begin
    rst   = 1'b1;
    value = 16'h3210;
    dp    = 4'b0000;
    blank = 4'b0000;
    lz_en = 1'b0;

    // Reset and scan order
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    check_frame({7'h06, 7'h12, 7'h4F, 7'h01}, 4'b1111, -1, 16'h0);

    // Snapshot: value changes mid-frame are deferred to the next frame
    value = 16'h0000;
    check_frame({7'h01, 7'h01, 7'h01, 7'h01}, 4'b1111, 10, 16'hFFFF);
    check_frame({7'h38, 7'h38, 7'h38, 7'h38}, 4'b1111, -1, 16'h0);

    // Leading-zero suppression
    value = 16'h00A0;
    lz_en = 1'b1;
    check_frame({7'h7F, 7'h7F, 7'h08, 7'h01}, 4'b1111, -1, 16'h0);
    value = 16'h0000;
    dp    = 4'b0010;
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1101, -1, 16'h0);

    // Blank and decimal point
    value = 16'h3210;
    lz_en = 1'b0;
    dp    = 4'b0101;
    blank = 4'b0100;
    check_frame({7'h06, 7'h7F, 7'h4F, 7'h01}, 4'b1110, -1, 16'h0);

    // Mid-frame reset during digit 2
    repeat (12) @(negedge clk);
    chk("pre_reset_an", 16'(an_n), 16'h000B);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset_held");
    check_frame({7'h06, 7'h7F, 7'h4F, 7'h01}, 4'b1110, -1, 16'h0);

    // Anode invariants under changing inputs over 10 frames
    for (int c = 0; c < 200; c++) begin
      if (c % 7 == 0) begin
        value = 16'($urandom);
        dp    = 4'($urandom);
        blank = 4'($urandom);
        lz_en = 1'($urandom);
      end
      @(negedge clk);
      chk("an_onehot", 16'($countones(~an_n) <= 1), 16'h0001);
      if (an_n == 4'hF) chk("guard_seg_off", 16'(seg_n), 16'h007F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
